// File: rtl/lbist_session_ctrl.sv
// Fault-injection campaign sequencer: restarts the TPG for each injected fault,
// compares faulty vs fault-free CUT outputs (per pattern or by dual MISR) and counts detections.
module lbist_session_ctrl #(
    parameter int                  OUT_BITS   = 2,
    parameter int                  FAULT_BITS = 5,
    parameter int                  SIG_BITS   = 16,
    parameter logic [SIG_BITS-1:0] MISR_POLY  = 16'h002D,
    parameter int                  PAT_BITS   = 8,
    parameter int                  PIPE_LAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  early_abort,
    input  logic [FAULT_BITS-1:0] num_faults,
    input  logic                  tpg_end,
    input  logic [OUT_BITS-1:0]   cut_op,
    input  logic [OUT_BITS-1:0]   ff_op,
    output logic                  tpg_hold,
    output logic                  fil_inc,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  det_flag,
    output logic [FAULT_BITS-1:0] fault_idx,
    output logic [FAULT_BITS-1:0] err_count,
    output logic [SIG_BITS-1:0]   signature,
    output logic [SIG_BITS-1:0]   golden_sig
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESTART, S_RUN, S_DRAIN, S_EVAL, S_NEXT, S_DONE
    } state_t;

    localparam logic [PAT_BITS-1:0]   CNT_LAST   = {{(PAT_BITS-1){1'b1}}, 1'b0};
    localparam logic [1:0]            DRAIN_LAST = (PIPE_LAT > 0) ? 2'(PIPE_LAT - 1) : 2'd0;
    localparam logic [FAULT_BITS-1:0] ONE_F      = 1;

    state_t                state, state_nxt;
    logic                  mode_q, abort_q, mismatch, timeout_q;
    logic [FAULT_BITS-1:0] num_q;
    logic [PAT_BITS-1:0]   cnt;
    logic [1:0]            drain_cnt;
    logic [SIG_BITS-1:0]   misr_cut, misr_ff, misr_cut_nxt, misr_ff_nxt;
    logic                  run_sampled, sample, op_diff, detected, last_fault;

    function automatic logic [SIG_BITS-1:0] misr_step(input logic [SIG_BITS-1:0] sig,
                                                      input logic [OUT_BITS-1:0] op);
        return (sig << 1) ^ (sig[SIG_BITS-1] ? MISR_POLY : '0) ^ SIG_BITS'(op);
    endfunction

    // The pipeline-latency guard folds away entirely when outputs are valid immediately.
    generate
        if (PIPE_LAT == 0) begin : g_nolat
            assign run_sampled = 1'b1;
        end else begin : g_lat
            assign run_sampled = (cnt >= PAT_BITS'(PIPE_LAT));
        end
    endgenerate

    assign op_diff      = |(cut_op ^ ff_op);
    assign sample       = (state == S_RUN && run_sampled) || (state == S_DRAIN);
    assign misr_cut_nxt = sample ? misr_step(misr_cut, cut_op) : misr_cut;
    assign misr_ff_nxt  = sample ? misr_step(misr_ff, ff_op) : misr_ff;
    assign detected     = mode_q ? (signature != golden_sig) : mismatch;
    assign last_fault   = (fault_idx == num_q - ONE_F);
    assign timeout      = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        tpg_hold  = 1'b1;
        fil_inc   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        det_flag  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) state_nxt = (num_faults == '0) ? S_DONE : S_RESTART;
            end
            S_RESTART: begin
                busy      = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy     = 1'b1;
                tpg_hold = 1'b0;
                if (run_sampled && tpg_end)
                    state_nxt = (PIPE_LAT > 0) ? S_DRAIN : S_EVAL;
                else if (!mode_q && abort_q && run_sampled && op_diff)
                    state_nxt = S_EVAL;
                else if (cnt == CNT_LAST)
                    state_nxt = S_DONE;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                busy      = 1'b1;
                det_flag  = detected;
                state_nxt = S_NEXT;
            end
            S_NEXT: begin
                busy      = 1'b1;
                fil_inc   = rst;
                state_nxt = last_fault ? S_DONE : S_RESTART;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q     <= 1'b0;
            abort_q    <= 1'b0;
            num_q      <= '0;
            mismatch   <= 1'b0;
            timeout_q  <= 1'b0;
            cnt        <= '0;
            drain_cnt  <= '0;
            misr_cut   <= '0;
            misr_ff    <= '0;
            fault_idx  <= '0;
            err_count  <= '0;
            signature  <= '0;
            golden_sig <= '0;
        end else begin
            misr_cut <= misr_cut_nxt;
            misr_ff  <= misr_ff_nxt;
            if (sample) mismatch <= mismatch | op_diff;
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    mode_q    <= mode;
                    abort_q   <= early_abort;
                    num_q     <= num_faults;
                    err_count <= '0;
                    fault_idx <= '0;
                    timeout_q <= 1'b0;
                end
                S_RESTART: begin
                    misr_cut  <= '0;
                    misr_ff   <= '0;
                    mismatch  <= 1'b0;
                    cnt       <= '0;
                    drain_cnt <= '0;
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (state_nxt == S_DONE) timeout_q <= 1'b1;
                end
                S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
                S_EVAL:  if (detected) err_count <= err_count + ONE_F;
                S_NEXT:  if (!last_fault) fault_idx <= fault_idx + ONE_F;
                default: ;
            endcase
            // Published signatures include the final sample taken on the way into EVAL.
            if (state_nxt == S_EVAL && state != S_EVAL) begin
                signature  <= misr_cut_nxt;
                golden_sig <= misr_ff_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lbist_session_ctrl.sv
// Directed bench for lbist_session_ctrl: a behavioural TPG/CUT pair feeds patterns,
// and each scenario task checks counts, pulse totals, latency and signatures.
module tb_lbist_session_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, mode, early_abort, tpg_end;
    logic [4:0] num_faults;
    logic [1:0] cut_op, ff_op;
    logic       tpg_hold, fil_inc, busy, done, timeout, det_flag;
    logic [4:0] fault_idx, err_count;
    logic [15:0] signature, golden_sig;

    int total = 0;
    int bad   = 0;
    int fil_cnt, det_cnt, cyc;

    // Environment: TPG counts patterns while released; one fault flips a CUT output bit.
    logic [7:0] pat = 8'd0;
    logic [7:0] npat = 8'd4;
    logic       use_end = 1'b1;
    logic [4:0] bad_fault = 5'd31;
    logic [7:0] bad_pat = 8'd2;
    logic [1:0] flip = 2'b01;

    always #5 clk = ~clk;

    always @(posedge clk) pat <= tpg_hold ? 8'd0 : pat + 8'd1;

    assign tpg_end = use_end && !tpg_hold && (pat == npat - 8'd1);
    assign ff_op   = 2'(pat + 8'd1);
    assign cut_op  = ff_op ^ ((!tpg_hold && fault_idx == bad_fault && pat == bad_pat) ? flip : 2'b00);

    always @(negedge clk) begin
        if (fil_inc)  fil_cnt++;
        if (det_flag) det_cnt++;
    end

    lbist_session_ctrl #(
        .OUT_BITS(2), .FAULT_BITS(5), .SIG_BITS(16), .MISR_POLY(16'h002D),
        .PAT_BITS(4), .PIPE_LAT(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .early_abort(early_abort),
        .num_faults(num_faults), .tpg_end(tpg_end), .cut_op(cut_op), .ff_op(ff_op),
        .tpg_hold(tpg_hold), .fil_inc(fil_inc), .busy(busy), .done(done),
        .timeout(timeout), .det_flag(det_flag), .fault_idx(fault_idx),
        .err_count(err_count), .signature(signature), .golden_sig(golden_sig)
    );

    task automatic run_session(input logic [4:0] n, input logic m, input logic ab);
        @(negedge clk);
        num_faults  = n;
        mode        = m;
        early_abort = ab;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        fil_cnt = 0;
        det_cnt = 0;
    endtask

    task automatic wait_done(input int limit);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tpg_hold !== 1'b1)  begin bad++; $display("FAIL reset_hold: got %b want 1", tpg_hold); end
        total++; if ({busy, done, timeout, fil_inc, det_flag} !== 5'b0)
            begin bad++; $display("FAIL reset_flags: got %b want 00000", {busy, done, timeout, fil_inc, det_flag}); end
        total++; if ({fault_idx, err_count} !== 10'd0)
            begin bad++; $display("FAIL reset_counts: got %h want 0", {fault_idx, err_count}); end
        total++; if ({signature, golden_sig} !== 32'd0)
            begin bad++; $display("FAIL reset_sigs: got %h want 0", {signature, golden_sig}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_compare;
        bad_fault = 5'd1; bad_pat = 8'd2; flip = 2'b01; use_end = 1'b1;
        run_session(5'd3, 1'b0, 1'b0);
        wait_done(100);
        total++; if (cyc != 21)          begin bad++; $display("FAIL cmp_latency: got %0d want 21", cyc); end
        total++; if (err_count !== 5'd1) begin bad++; $display("FAIL cmp_err: got %0d want 1", err_count); end
        total++; if (det_cnt != 1)       begin bad++; $display("FAIL cmp_det: got %0d want 1", det_cnt); end
        total++; if (fil_cnt != 3)       begin bad++; $display("FAIL cmp_fil: got %0d want 3", fil_cnt); end
        total++; if (fault_idx !== 5'd2) begin bad++; $display("FAIL cmp_idx: got %0d want 2", fault_idx); end
        total++; if ({busy, timeout, tpg_hold} !== 3'b001)
            begin bad++; $display("FAIL cmp_status: got %b want 001", {busy, timeout, tpg_hold}); end
    endtask

    task automatic test_early_abort;
        run_session(5'd3, 1'b0, 1'b1);
        wait_done(100);
        total++; if (cyc != 20)          begin bad++; $display("FAIL abort_latency: got %0d want 20", cyc); end
        total++; if (err_count !== 5'd1) begin bad++; $display("FAIL abort_err: got %0d want 1", err_count); end
        total++; if (fil_cnt != 3)       begin bad++; $display("FAIL abort_fil: got %0d want 3", fil_cnt); end
    endtask

    task automatic test_signature;
        bad_fault = 5'd31;
        run_session(5'd2, 1'b1, 1'b0);
        wait_done(100);
        total++; if (err_count !== 5'd0)      begin bad++; $display("FAIL sig_clean_err: got %0d want 0", err_count); end
        total++; if (golden_sig !== 16'h0006) begin bad++; $display("FAIL sig_golden: got %h want 0006", golden_sig); end
        total++; if (signature !== 16'h0006)  begin bad++; $display("FAIL sig_clean: got %h want 0006", signature); end
        bad_fault = 5'd1; bad_pat = 8'd2; flip = 2'b01;
        run_session(5'd2, 1'b1, 1'b0);
        wait_done(100);
        total++; if (err_count !== 5'd1)      begin bad++; $display("FAIL sig_flip_err: got %0d want 1", err_count); end
        total++; if (signature !== 16'h0004)  begin bad++; $display("FAIL sig_flip: got %h want 0004", signature); end
        total++; if (det_cnt != 1)            begin bad++; $display("FAIL sig_flip_det: got %0d want 1", det_cnt); end
    endtask

    task automatic test_timeout;
        use_end = 1'b0; bad_fault = 5'd31;
        run_session(5'd3, 1'b0, 1'b0);
        wait_done(100);
        use_end = 1'b1;
        total++; if (cyc != 16)          begin bad++; $display("FAIL to_latency: got %0d want 16", cyc); end
        total++; if (timeout !== 1'b1)   begin bad++; $display("FAIL to_flag: got %b want 1", timeout); end
        total++; if (fil_cnt != 0)       begin bad++; $display("FAIL to_fil: got %0d want 0", fil_cnt); end
        total++; if (err_count !== 5'd0) begin bad++; $display("FAIL to_err: got %0d want 0", err_count); end
    endtask

    task automatic test_zero_and_busy_start;
        run_session(5'd0, 1'b0, 1'b0);
        total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL zero_done: got %b want 10", {done, busy}); end
        total++; if (timeout !== 1'b0)       begin bad++; $display("FAIL zero_to_clear: got %b want 0", timeout); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (fil_cnt != 0)           begin bad++; $display("FAIL zero_fil: got %0d want 0", fil_cnt); end
        run_session(5'd2, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        num_faults = 5'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL busy_start: got %b want 10", {busy, done}); end
        wait_done(100);
        total++; if (cyc != 10)              begin bad++; $display("FAIL busy_latency: got %0d want 10", cyc); end
        total++; if (fil_cnt != 2)           begin bad++; $display("FAIL busy_fil: got %0d want 2", fil_cnt); end
    endtask

    task automatic test_mid_reset;
        bad_fault = 5'd1; bad_pat = 8'd0;
        run_session(5'd3, 1'b0, 1'b0);
        cyc = 0;
        while (!(fault_idx == 5'd2 && !tpg_hold) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total++; if (err_count !== 5'd1) begin bad++; $display("FAIL mid_pre_err: got %0d want 1", err_count); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if ({tpg_hold, busy, fil_inc} !== 3'b100)
            begin bad++; $display("FAIL mid_rst_ctl: got %b want 100", {tpg_hold, busy, fil_inc}); end
        total++; if ({err_count, fault_idx} !== 10'd0)
            begin bad++; $display("FAIL mid_rst_counts: got %h want 0", {err_count, fault_idx}); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (fil_cnt != 2)       begin bad++; $display("FAIL mid_fil: got %0d want 2", fil_cnt); end
        total++; if ({busy, done} !== 2'b00)
            begin bad++; $display("FAIL mid_idle: got %b want 00", {busy, done}); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode = 1'b0; early_abort = 1'b0; num_faults = 5'd0;
        fil_cnt = 0; det_cnt = 0; cyc = 0;
        test_reset;
        test_compare;
        test_early_abort;
        test_signature;
        test_timeout;
        test_zero_and_busy_start;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
